// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the redundant-Ethernet transmit path.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_META,
    ST_PAYLOAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

  localparam int PREAMBLE_LEN   = 8;
  localparam int HEADER_LEN     = 14;
  localparam int META_LEN       = 4;
  localparam int FCS_LEN        = 4;
  localparam int HEADER_OFFSET  = 8;
  localparam int META_OFFSET    = 22;
  localparam int PAYLOAD_OFFSET = 26;

  // Reflected (LSB-first) CRC-32 update for one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected IEEE 802.3 CRC-32 register; init has priority over calc.
// Result reflects every byte presented on a calc cycle from the following clock on.
module crc32_d8
  import eth_tx_pkg::*;
(
  input  logic        clk125MHz,
  input  logic        resetn,
  input  logic        init,
  input  logic        calc,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  always_ff @(posedge clk125MHz or negedge resetn) begin
    if (!resetn) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (calc) begin
      crc <= crc32_byte(crc, d);
    end
  end

endmodule

// File: rtl/tx_redundant_framer.sv
// Emits each segment as `redundancy` back-to-back Ethernet frames, one registered byte per tx_ce slot.
// First byte appears one clock after the tx_ce edge that sees enable; tx_ce=0 freezes all state and outputs.
module tx_redundant_framer
  import eth_tx_pkg::*;
#(
  parameter int          PAYLOAD_LEN = 46,
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0002_2300_0001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          IFG_BYTES   = 12
) (
  input  logic        clk125MHz,
  input  logic        resetn,
  input  logic        tx_ce,
  input  logic        enable,
  input  logic [7:0]  redundancy,
  input  logic [7:0]  segment_number_max,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        busy,
  output logic [31:0] frames_sent
);

  localparam logic [111:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};

  tx_state_t   state, state_nxt;
  logic [10:0] cnt, cnt_nxt;
  logic [7:0]  byte_nxt;
  logic        en_nxt;
  logic [31:0] crc, fcs;
  logic        crc_init, crc_calc, frame_start, frame_end;
  logic [7:0]  red_q, seg_max_q, copy_idx, seg_num, frame_id;
  logic [8:0]  copy_inc, seg_inc;

  // state/cnt name the byte currently on tx_data; *_nxt names the byte loaded at the next tx_ce edge
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 11'd1;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (enable) state_nxt = ST_PREAMBLE;
      end
      ST_PREAMBLE: if (cnt == 11'(PREAMBLE_LEN - 1)) begin state_nxt = ST_HEADER;  cnt_nxt = '0; end
      ST_HEADER:   if (cnt == 11'(HEADER_LEN - 1))   begin state_nxt = ST_META;    cnt_nxt = '0; end
      ST_META:     if (cnt == 11'(META_LEN - 1))     begin state_nxt = ST_PAYLOAD; cnt_nxt = '0; end
      ST_PAYLOAD:  if (cnt == 11'(PAYLOAD_LEN - 1))  begin state_nxt = ST_FCS;     cnt_nxt = '0; end
      ST_FCS:      if (cnt == 11'(FCS_LEN - 1))      begin state_nxt = ST_IFG;     cnt_nxt = '0; end
      ST_IFG: begin
        if (cnt == 11'(IFG_BYTES - 1)) begin
          state_nxt = enable ? ST_PREAMBLE : ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign fcs = ~crc;

  always_comb begin
    byte_nxt = 8'h00;
    en_nxt   = 1'b1;
    case (state_nxt)
      ST_PREAMBLE: byte_nxt = (cnt_nxt == 11'(PREAMBLE_LEN - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
      ST_HEADER: begin
        for (int i = 0; i < HEADER_LEN; i++) begin
          if (cnt_nxt == 11'(i)) byte_nxt = HDR_BYTES[111 - 8*i -: 8];
        end
      end
      ST_META: begin
        case (cnt_nxt[1:0])
          2'd0:    byte_nxt = copy_idx;
          2'd1:    byte_nxt = 8'h00;
          2'd2:    byte_nxt = seg_num;
          default: byte_nxt = frame_id;
        endcase
      end
      ST_PAYLOAD: byte_nxt = frame_id + cnt_nxt[7:0];
      ST_FCS: begin
        case (cnt_nxt[1:0])
          2'd0:    byte_nxt = fcs[7:0];
          2'd1:    byte_nxt = fcs[15:8];
          2'd2:    byte_nxt = fcs[23:16];
          default: byte_nxt = fcs[31:24];
        endcase
      end
      default: en_nxt = 1'b0;
    endcase
  end

  // CRC folds in each byte on the same edge that launches it, so FCS byte 0 is ready without a bubble
  assign crc_init    = tx_ce && (state_nxt == ST_PREAMBLE);
  assign crc_calc    = tx_ce && (state_nxt inside {ST_HEADER, ST_META, ST_PAYLOAD});
  assign frame_start = tx_ce && (state_nxt == ST_PREAMBLE) && (state != ST_PREAMBLE);
  assign frame_end   = tx_ce && (state == ST_FCS) && (cnt == 11'(FCS_LEN - 1));
  assign copy_inc    = {1'b0, copy_idx} + 9'd1;
  assign seg_inc     = {1'b0, seg_num} + 9'd1;

  crc32_d8 u_crc (
    .clk125MHz (clk125MHz),
    .resetn    (resetn),
    .init      (crc_init),
    .calc      (crc_calc),
    .d         (byte_nxt),
    .crc       (crc)
  );

  always_ff @(posedge clk125MHz or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      tx_data     <= 8'h00;
      tx_en       <= 1'b0;
      frames_sent <= '0;
      red_q       <= 8'd1;
      seg_max_q   <= 8'd1;
      copy_idx    <= '0;
      seg_num     <= '0;
      frame_id    <= '0;
    end else if (tx_ce) begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tx_data <= byte_nxt;
      tx_en   <= en_nxt;
      if (frame_start) begin
        red_q     <= (redundancy == 8'd0) ? 8'd1 : redundancy;
        seg_max_q <= (segment_number_max == 8'd0) ? 8'd1 : segment_number_max;
      end
      if (frame_end) begin
        frames_sent <= frames_sent + 32'd1;
        if (copy_inc >= {1'b0, red_q}) begin
          copy_idx <= '0;
          frame_id <= frame_id + 8'd1;
          seg_num  <= (seg_inc >= {1'b0, seg_max_q}) ? 8'd0 : seg_inc[7:0];
        end else begin
          copy_idx <= copy_inc[7:0];
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_tx_redundant_framer.sv
// Bench for tx_redundant_framer: slot-level capture compared against a frame-level reference model.
module tb_tx_redundant_framer;

  localparam int PL   = 46;
  localparam int IFG  = 12;
  localparam int FLEN = 8 + 14 + 4 + PL + 4;
  localparam int SLOT = FLEN + IFG;
  localparam logic [111:0] HDR = {48'hFFFF_FFFF_FFFF, 48'h0002_2300_0001, 16'h88B5};

  logic        clk125MHz;
  logic        resetn;
  logic        tx_ce;
  logic        enable;
  logic [7:0]  redundancy;
  logic [7:0]  segment_number_max;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        busy;
  logic [31:0] frames_sent;

  int tests = 0;
  int fails = 0;
  int ce_div = 1;
  int ce_cnt = 0;
  int en_cnt = 0;
  int hold_err = 0;
  bit last_ce = 0;
  logic [8:0] prev_s = '0;
  logic [8:0] slot_q[$];
  logic [8:0] exp_q[$];

  tx_redundant_framer #(
    .PAYLOAD_LEN (PL),
    .DST_MAC     (48'hFFFF_FFFF_FFFF),
    .SRC_MAC     (48'h0002_2300_0001),
    .ETHERTYPE   (16'h88B5),
    .IFG_BYTES   (IFG)
  ) dut (
    .clk125MHz          (clk125MHz),
    .resetn             (resetn),
    .tx_ce              (tx_ce),
    .enable             (enable),
    .redundancy         (redundancy),
    .segment_number_max (segment_number_max),
    .tx_data            (tx_data),
    .tx_en              (tx_en),
    .busy               (busy),
    .frames_sent        (frames_sent)
  );

  initial begin
    clk125MHz = 0;
    forever #4 clk125MHz = ~clk125MHz;
  end

  initial begin
    tx_ce = 1;
    forever begin
      @(posedge clk125MHz);
      #1;
      ce_cnt = (ce_cnt + 1) % ce_div;
      tx_ce  = (ce_cnt == 0);
    end
  end

  // Log one entry per byte slot; between slots the outputs must not move.
  initial begin
    forever begin
      @(negedge clk125MHz);
      if (!resetn) begin
        last_ce = 0;
        prev_s  = '0;
      end else begin
        if (last_ce) begin
          slot_q.push_back({tx_en, tx_data});
          if (tx_en) en_cnt++;
        end else if ({tx_en, tx_data} !== prev_s) begin
          hold_err++;
        end
        prev_s  = {tx_en, tx_data};
        last_ce = tx_ce;
      end
    end
  end

  // Bit-serial reference CRC, LSB of each byte first.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int j = 0; j < 8; j++) begin
      fb = r[0] ^ b[j];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31 - i];
    return r;
  endfunction

  task automatic build_exp(input int red, input int smax, input int nfr);
    int r, s, copy, seg, fid;
    logic [31:0] c;
    logic [7:0] b;
    logic [111:0] h;
    r = (red == 0) ? 1 : red;
    s = (smax == 0) ? 1 : smax;
    h = HDR;
    exp_q.delete();
    for (int k = 0; k < nfr; k++) begin
      copy = k % r;
      seg  = (k / r) % s;
      fid  = (k / r) % 256;
      for (int i = 0; i < 7; i++) exp_q.push_back(9'h155);
      exp_q.push_back(9'h1D5);
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 18 + PL; i++) begin
        if (i < 14)       b = h[111 - 8*i -: 8];
        else if (i == 14) b = 8'(copy);
        else if (i == 15) b = 8'(seg >> 8);
        else if (i == 16) b = 8'(seg);
        else if (i == 17) b = 8'(fid);
        else              b = 8'(fid + i - 18);
        c = ref_crc(c, b);
        exp_q.push_back({1'b1, b});
      end
      c = ~c;
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, c[8*i +: 8]});
      for (int i = 0; i < IFG; i++) exp_q.push_back(9'h000);
    end
  endtask

  task automatic check_stream(input string name, input int nfr);
    int base, bad, idx;
    logic [31:0] c;
    base = -1;
    foreach (slot_q[i]) if (base < 0 && slot_q[i][8]) base = i;
    tests++;
    if (base < 0) begin
      fails++;
      $display("FAIL %s start: no tx_en slot seen, required a frame", name);
      return;
    end
    for (int f = 0; f < nfr; f++) begin
      bad = -1;
      for (int i = 0; i < SLOT; i++) begin
        idx = base + f*SLOT + i;
        if (idx >= slot_q.size() || slot_q[idx] !== exp_q[f*SLOT + i]) begin
          bad = i;
          break;
        end
      end
      tests++;
      if (bad >= 0) begin
        fails++;
        idx = base + f*SLOT + bad;
        $display("FAIL %s frame %0d slot %0d: got %h required %h (captured %0d slots)", name, f, bad,
                 (idx < slot_q.size()) ? slot_q[idx] : 9'h1FF, exp_q[f*SLOT + bad], slot_q.size());
      end
      tests++;
      if (base + f*SLOT + FLEN > slot_q.size()) begin
        fails++;
        $display("FAIL %s frame %0d residue: frame truncated, required %0d bytes", name, f, FLEN);
      end else begin
        c = 32'hFFFFFFFF;
        for (int i = 8; i < FLEN; i++) c = ref_crc(c, slot_q[base + f*SLOT + i][7:0]);
        if (rev32(c) !== 32'hC704DD7B) begin
          fails++;
          $display("FAIL %s frame %0d residue: got %h required c704dd7b", name, f, rev32(c));
        end
      end
    end
    bad = 0;
    for (int i = base + nfr*SLOT; i < slot_q.size(); i++) if (slot_q[i][8]) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s tail: got %0d extra tx_en slots required 0", name, bad);
    end
  endtask

  task automatic do_reset();
    resetn = 0;
    enable = 0;
    repeat (3) @(posedge clk125MHz);
    #1;
    slot_q.delete();
    en_cnt   = 0;
    hold_err = 0;
    resetn   = 1;
  endtask

  task automatic wait_frames(input int n, input int budget, input string what);
    int k = 0;
    while (frames_sent !== 32'(n) && k < budget) begin
      @(negedge clk125MHz);
      k++;
    end
    tests++;
    if (frames_sent !== 32'(n)) begin
      fails++;
      $display("FAIL %s wait frames: frames_sent=%0d required %0d", what, frames_sent, n);
    end
  endtask

  task automatic wait_en(input int n, input int budget, input string what);
    int k = 0;
    while (en_cnt < n && k < budget) begin
      @(negedge clk125MHz);
      k++;
    end
    tests++;
    if (en_cnt < n) begin
      fails++;
      $display("FAIL %s wait bytes: got %0d required %0d", what, en_cnt, n);
    end
  endtask

  task automatic wait_idle(input int budget, input string what);
    int k = 0;
    @(negedge clk125MHz);
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk125MHz);
      k++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s wait idle: busy=%b required 0", what, busy);
    end
  endtask

  task automatic run_frames(input string name, input int red, input int smax, input int n);
    do_reset();
    redundancy         = 8'(red);
    segment_number_max = 8'(smax);
    enable             = 1;
    wait_frames(n, n*SLOT*ce_div + 400, name);
    @(posedge clk125MHz);
    #1;
    enable = 0;
    wait_idle(SLOT*ce_div + 100, name);
    repeat (20*ce_div) @(posedge clk125MHz);
    build_exp(red, smax, n);
    check_stream(name, n);
  endtask

  task automatic test_reset();
    resetn = 0;
    enable = 0;
    redundancy = 0;
    segment_number_max = 0;
    repeat (2) @(negedge clk125MHz);
    tests++;
    if ({tx_en, tx_data, busy, frames_sent} !== '0) begin
      fails++;
      $display("FAIL reset_in: en=%b data=%h busy=%b frames=%0d required all 0", tx_en, tx_data, busy, frames_sent);
    end
    do_reset();
    repeat (5) @(negedge clk125MHz);
    tests++;
    if ({tx_en, tx_data, busy, frames_sent} !== '0) begin
      fails++;
      $display("FAIL reset_idle: en=%b data=%h busy=%b frames=%0d required all 0", tx_en, tx_data, busy, frames_sent);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    redundancy         = 8'd3;
    segment_number_max = 8'd2;
    enable             = 1;
    @(negedge clk125MHz);
    tests++;
    if (tx_en !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: tx_en=%b required 0", tx_en);
    end
    @(negedge clk125MHz);
    tests++;
    if (tx_en !== 1'b1 || tx_data !== 8'h55 || busy !== 1'b1) begin
      fails++;
      $display("FAIL latency_first: en=%b data=%h busy=%b required 1 55 1", tx_en, tx_data, busy);
    end
    wait_frames(6, 6*SLOT + 200, "sequence");
    @(posedge clk125MHz);
    #1;
    enable = 0;
    wait_idle(SLOT + 50, "sequence");
    repeat (30) @(posedge clk125MHz);
    build_exp(3, 2, 6);
    check_stream("sequence", 6);
    tests++;
    if (frames_sent !== 32'd6) begin
      fails++;
      $display("FAIL sequence_count: frames_sent=%0d required 6", frames_sent);
    end
  endtask

  task automatic test_slow_ce();
    ce_div = 10;
    run_frames("slow_ce", 3, 2, 2);
    tests++;
    if (hold_err != 0) begin
      fails++;
      $display("FAIL slow_ce_hold: got %0d output changes between tx_ce slots required 0", hold_err);
    end
    ce_div = 1;
  endtask

  task automatic test_enable_drop();
    int red, smax;
    red  = $urandom_range(1, 3);
    smax = $urandom_range(1, 3);
    do_reset();
    redundancy         = 8'(red);
    segment_number_max = 8'(smax);
    enable             = 1;
    wait_en(8 + 14 + 4 + 21, 200, "enable_drop");
    @(posedge clk125MHz);
    #1;
    enable = 0;
    wait_idle(SLOT + 50, "enable_drop");
    repeat (100) @(posedge clk125MHz);
    build_exp(red, smax, 1);
    check_stream("enable_drop", 1);
    tests++;
    if (frames_sent !== 32'd1 || busy !== 1'b0 || tx_en !== 1'b0) begin
      fails++;
      $display("FAIL enable_drop_end: frames=%0d busy=%b en=%b required 1 0 0", frames_sent, busy, tx_en);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      run_frames("random", $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(3, 7));
    end
  endtask

  task automatic test_zero_cfg();
    int base, i255, i256;
    run_frames("zero_cfg", 0, 0, 257);
    base = -1;
    foreach (slot_q[i]) if (base < 0 && slot_q[i][8]) base = i;
    i255 = base + 255*SLOT + 25;
    i256 = base + 256*SLOT + 25;
    tests++;
    if (base < 0 || i256 >= slot_q.size() || slot_q[i255][7:0] !== 8'd255 || slot_q[i256][7:0] !== 8'd0) begin
      fails++;
      $display("FAIL zero_cfg_wrap: id bytes of frames 255/256 not 255/0 (base %0d, %0d slots)", base, slot_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    redundancy         = 8'd3;
    segment_number_max = 8'd2;
    enable             = 1;
    wait_en(4*FLEN + 8 + 3, 5*SLOT, "reset_mid");
    @(posedge clk125MHz);
    #1;
    resetn = 0;
    #1;
    tests++;
    if ({tx_en, tx_data, busy, frames_sent} !== '0) begin
      fails++;
      $display("FAIL reset_mid_now: en=%b data=%h busy=%b frames=%0d required all 0", tx_en, tx_data, busy, frames_sent);
    end
    repeat (2) @(posedge clk125MHz);
    #1;
    slot_q.delete();
    en_cnt = 0;
    resetn = 1;
    wait_frames(1, SLOT + 50, "reset_mid");
    @(posedge clk125MHz);
    #1;
    enable = 0;
    wait_idle(SLOT + 50, "reset_mid");
    repeat (20) @(posedge clk125MHz);
    build_exp(3, 2, 1);
    check_stream("reset_mid", 1);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_slow_ce();
    test_enable_drop();
    test_random();
    test_zero_cfg();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
